// File: rtl/seq_alu.sv
// Multi-cycle EX-stage execute unit: single-cycle logic/arithmetic,
// iterative one-bit-per-cycle shifts with Ready/Done handshake.
module seq_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Start,
  input  logic                  Flush,
  output logic                  Ready,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [3:0]             op_q;

  logic [DATA_WIDTH-1:0]  alu_res;
  logic [DATA_WIDTH-1:0]  shift_nxt;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;

  assign shamt    = SrcB[SHAMT_WIDTH-1:0];
  assign is_shift = (Operation == OP_SRL) ||
                    (Operation == OP_SLL) ||
                    (Operation == OP_SRA);
  assign Ready    = reset_n && (state == IDLE);

  // Shift ops only reach this path with a zero shift amount.
  always_comb begin
    alu_res = '0;
    unique case (Operation)
      OP_AND: alu_res = SrcA & SrcB;
      OP_XOR: alu_res = SrcA ^ SrcB;
      OP_ADD: alu_res = SrcA + SrcB;
      OP_OR:  alu_res = SrcA | SrcB;
      OP_SUB: alu_res = SrcA - SrcB;
      OP_SRL: alu_res = SrcA;
      OP_SLL: alu_res = SrcA;
      OP_SRA: alu_res = SrcA;
      OP_EQ:  alu_res = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}},
                         $signed(SrcA) < $signed(SrcB)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    shift_nxt = '0;
    unique case (op_q)
      OP_SRL:  shift_nxt = {1'b0, acc[DATA_WIDTH-1:1]};
      OP_SLL:  shift_nxt = {acc[DATA_WIDTH-2:0], 1'b0};
      default: shift_nxt = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      Result <= '0;
      Zero   <= 1'b1;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (Start) begin
              if (is_shift && shamt != '0) begin
                acc   <= SrcA;
                cnt   <= shamt;
                op_q  <= Operation;
                state <= SHIFT;
              end else begin
                Result <= alu_res;
                Zero   <= (alu_res == '0);
                Done   <= 1'b1;
              end
            end
          end
          SHIFT: begin
            acc <= shift_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == SHAMT_WIDTH'(1)) begin
              Result <= shift_nxt;
              Zero   <= (shift_nxt == '0);
              Done   <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes expected results,
// monitor pops on every Done and checks value, flag and cycle.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         Start;
  logic         Flush;
  logic         Ready;
  logic         Done;
  logic [W-1:0] Result;
  logic         Zero;

  seq_alu #(.DATA_WIDTH(W), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .Start(Start), .Flush(Flush),
    .Ready(Ready), .Done(Done), .Result(Result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(
    input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = int'(b[4:0]);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a ^ b;
      4'd2:  return a + b;
      4'd3:  return a | b;
      4'd4:  return a - b;
      4'd5:  return a >> n;
      4'd6:  return a << n;
      4'd7:  return W'($signed(a) >>> n);
      4'd8:  return (a == b) ? W'(1) : W'(0);
      4'd12: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding op.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && Done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got Done at cyc %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("result", Result, e.res);
        check("zero", W'(Zero), W'(e.res == '0));
        check("done_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit keep);
    int w;
    exp_t e;
    int n;
    w = 0;
    while (Ready !== 1'b1 && w < 200) begin
      step();
      w++;
    end
    if (Ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got Ready=%b expected 1", Ready);
    end
    n = int'(b[4:0]);
    Operation = op;
    SrcA = a;
    SrcB = b;
    Start = 1'b1;
    if (keep) begin
      e.cyc = cyc + 1 + ((op >= 4'd5 && op <= 4'd7) ? n : 0);
      e.res = model(op, a, b);
      sb.push_back(e);
      last_res = e.res;
    end
    step();
    Start = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      step();
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    Start = 1'b0;
    Flush = 1'b0;
    Operation = '0;
    SrcA = '0;
    SrcB = '0;
    step();
    step();
    check("rst_ready", W'(Ready), W'(0));
    check("rst_result", Result, W'(0));
    check("rst_zero", W'(Zero), W'(1));
    check("rst_done", W'(Done), W'(0));
    reset_n = 1'b1;
    #1;
    check("rel_ready", W'(Ready), W'(1));

    issue(4'd2, 32'h7FFF_FFFF, 32'h1, 1);
    issue(4'd4, 32'd5, 32'd5, 1);
    issue(4'd12, 32'hFFFF_FFFF, 32'd1, 1);
    drain();

    issue(4'd7, 32'h8000_0000, 32'h0000_0104, 1);
    check("sra_busy", W'(Ready), W'(0));
    drain();
    issue(4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 1);
    issue(4'd5, 32'hFFFF_FFFF, 32'd31, 1);
    drain();

    // Start pulsed while busy must be ignored.
    issue(4'd6, 32'h1, 32'd8, 1);
    step();
    Operation = 4'd2;
    SrcA = 32'd1;
    SrcB = 32'd1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    drain();
    repeat (5) step();

    // Flush on the third SHIFT cycle, together with a Start.
    issue(4'd5, 32'h400, 32'd10, 0);
    step();
    step();
    Flush = 1'b1;
    Start = 1'b1;
    Operation = 4'd2;
    step();
    Flush = 1'b0;
    Start = 1'b0;
    check("flush_ready", W'(Ready), W'(1));
    check("flush_result", Result, last_res);
    repeat (15) step();
    check("flush_hold", Result, last_res);

    // Reset in the middle of a shift.
    issue(4'd6, 32'h3, 32'd20, 0);
    repeat (3) step();
    reset_n = 1'b0;
    step();
    check("mid_rst_result", Result, W'(0));
    check("mid_rst_zero", W'(Zero), W'(1));
    check("mid_rst_ready", W'(Ready), W'(0));
    reset_n = 1'b1;
    #1;
    issue(4'd8, 32'h12, 32'h12, 1);
    issue(4'd15, 32'h55, 32'h66, 1);
    drain();
    repeat (25) step();

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      issue(op, $urandom, $urandom, 1);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
